// File: rtl/cpu_step_ctrl.sv
// Run/halt/step execution controller: debounces three pushbuttons, arbitrates press events
// against a datapath halt request and issues processor clock-enable pulses. Optional breakpoint: STEP_CTRL_BREAKPOINT_EN.
module cpu_step_ctrl #(
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned DB_LEN   = 3,
  parameter int unsigned RUN_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_run,
  input  logic        btn_halt,
  input  logic        btn_step,
  input  logic        halt_req,
`ifdef STEP_CTRL_BREAKPOINT_EN
  input  logic [31:0] bp_addr,
  input  logic        bp_valid,
  input  logic [31:0] pc,
`endif
  output logic        cpu_en,
  output logic [1:0]  mode,
  output logic [15:0] step_count,
  output logic [2:0]  press_seen
);

  localparam int unsigned NBTN     = 3;
  localparam int unsigned BTN_RUN  = 0;
  localparam int unsigned BTN_HALT = 1;
  localparam int unsigned BTN_STEP = 2;
  localparam int unsigned TICK_W   = $clog2(TICK_DIV);
  localparam int unsigned RUN_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_e;

  logic [NBTN-1:0]   btn_raw_c;
  logic [NBTN-1:0]   sync1_q, sync2_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick_c;
  logic [DB_LEN-1:0] shift_q [NBTN];
  logic [DB_LEN-1:0] shift_d [NBTN];
  logic [NBTN-1:0]   level_q, level_d, level_prev_q;
  logic [NBTN-1:0]   press_c;
  logic [NBTN-1:0]   press_seen_q;

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              cpu_en_q, cpu_en_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  step_cnt_q;
  logic              bp_hit_c;

  assign btn_raw_c = {btn_step, btn_halt, btn_run};

  // Sample tick generator
  assign tick_c = (tick_q == TICK_W'(TICK_DIV - 1));
  assign tick_d = tick_c ? '0 : tick_q + TICK_W'(1);

  // Debounce: level changes only when the whole sample window agrees
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      shift_d[i] = shift_q[i];
      level_d[i] = level_q[i];
      if (tick_c) begin
        shift_d[i] = {shift_q[i][DB_LEN-2:0], sync2_q[i]};
        if (&shift_d[i]) begin
          level_d[i] = 1'b1;
        end else if (~|shift_d[i]) begin
          level_d[i] = 1'b0;
        end
      end
    end
  end

  assign press_c = level_q & ~level_prev_q;

`ifdef STEP_CTRL_BREAKPOINT_EN
  logic bp_armed_q, bp_armed_d;
  logic bp_match_c;

  assign bp_match_c = bp_valid && (pc == bp_addr);
  assign bp_hit_c   = bp_match_c && bp_armed_q;

  // Disarm when resuming from the breakpoint address; re-arm once pc moves away
  always_comb begin
    bp_armed_d = bp_armed_q;
    if (pc != bp_addr) begin
      bp_armed_d = 1'b1;
    end else if ((state_q == S_HALT) && (state_d == S_RUN)) begin
      bp_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_armed_q <= 1'b1;
    end else begin
      bp_armed_q <= bp_armed_d;
    end
  end
`else
  assign bp_hit_c = 1'b0;
`endif

  // Next state with fixed priority: halt_req > halt > step > run; losers are dropped
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    cpu_en_d  = 1'b0;
    mode_d    = 2'b00;
    case (state_q)
      S_HALT: begin
        if (halt_req || press_c[BTN_HALT]) begin
          state_d = S_HALT;
        end else if (press_c[BTN_STEP]) begin
          state_d = S_STEP;
        end else if (press_c[BTN_RUN]) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
      end
      S_RUN: begin
        if (halt_req || bp_hit_c || press_c[BTN_HALT]) begin
          state_d = S_HALT;
        end else if (run_cnt_q == RUN_W'(RUN_DIV - 1)) begin
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    cpu_en_d = (state_d == S_STEP) || ((state_d == S_RUN) && (run_cnt_d == '0));
    mode_d   = 2'(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      tick_q       <= '0;
      for (int i = 0; i < NBTN; i++) begin
        shift_q[i] <= '0;
      end
      level_q      <= '0;
      level_prev_q <= '0;
      press_seen_q <= '0;
      state_q      <= S_HALT;
      run_cnt_q    <= '0;
      cpu_en_q     <= 1'b0;
      mode_q       <= 2'b00;
      step_cnt_q   <= '0;
    end else begin
      sync1_q      <= btn_raw_c;
      sync2_q      <= sync1_q;
      tick_q       <= tick_d;
      for (int i = 0; i < NBTN; i++) begin
        shift_q[i] <= shift_d[i];
      end
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_seen_q <= press_seen_q | press_c;
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      cpu_en_q     <= cpu_en_d;
      mode_q       <= mode_d;
      step_cnt_q   <= step_cnt_q + CNT_W'(cpu_en_q);
    end
  end

  assign cpu_en     = cpu_en_q;
  assign mode       = mode_q;
  assign step_count = step_cnt_q;
  assign press_seen = press_seen_q;

endmodule
